// File: rtl/seq_d_1001.sv
// seq_d_1001: Moore FSM that watches a serial bit stream and flags the
// pattern 1-0-0-1. The flag is decoded from the state register only, so it
// rises in the cycle after the final '1' is sampled and lasts one cycle.
// OVERLAP selects whether the trailing '1' of a match may begin the next one.
module seq_d_1001 #(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic in,
    output logic out
);

    // State names track how much of the pattern is currently matched.
    // Binary encoding; the three spare codes fall into the default arm
    // below and recover to S_IDLE on the next edge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_100  = 3'd3,
        S_1001 = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register with synchronous active-low reset (reset beats in).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a '1' always restarts at least a partial match.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = in ? S_1    : S_IDLE;
            S_1:     state_nxt = in ? S_1    : S_10;
            S_10:    state_nxt = in ? S_1    : S_100;
            S_100:   state_nxt = in ? S_1001 : S_IDLE;
            S_1001: begin
                // Overlapping mode reuses the trailing '1' as the new prefix,
                // so a following '0' leaves "10" already matched.
                if (in) begin
                    state_nxt = S_1;
                end else if (OVERLAP != 0) begin
                    state_nxt = S_10;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: pure function of the state register, no path from in.
    always_comb begin
        out = (state == S_1001);
    end

endmodule

// File: tb/tb_seq_d_1001.sv
// tb_seq_d_1001: directed checks of the 1001 detector in both overlapping
// and non-overlapping builds, followed by a seeded random run that wiggles
// the input on both clock edges and compares against a shift-register model.
module tb_seq_d_1001;

    logic clk;
    logic rstn;
    logic din;
    logic out_o;   // OVERLAP=1 instance
    logic out_n;   // OVERLAP=0 instance

    int total;
    int bad;

    seq_d_1001 #(.OVERLAP(1)) dut_o (
        .clk  (clk),
        .rstn (rstn),
        .in   (din),
        .out  (out_o)
    );

    seq_d_1001 #(.OVERLAP(0)) dut_n (
        .clk  (clk),
        .rstn (rstn),
        .in   (din),
        .out  (out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one bit, clock it in, then check both detectors just after the edge.
    task automatic step(input logic b, input logic r, input logic exp_o,
                        input logic exp_n, input string tag);
        din  = b;
        rstn = r;
        @(posedge clk);
        #1;
        chk({tag, "_ovl"}, out_o, exp_o);
        chk({tag, "_non"}, out_n, exp_n);
    endtask

    task automatic do_reset(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, tag);
        rstn = 1'b1;
    endtask

    // Feed a bit vector MSB-first; expected flag patterns given per build.
    task automatic seq(input int n, input logic [15:0] bits,
                       input logic [15:0] eo, input logic [15:0] en,
                       input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, eo[i], en[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    logic [3:0] hist_o, hist_n;
    int         cnt_o, cnt_n;
    logic       m_o, m_n, b, g;

    initial begin
        total = 0;
        bad   = 0;
        din   = 1'b0;
        rstn  = 1'b0;
        #2;

        // Reset held 3 edges while in toggles, then released with in=0.
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst_e1");
        step(1'b0, 1'b0, 1'b0, 1'b0, "rst_e2");
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst_e3");
        step(1'b0, 1'b1, 1'b0, 1'b0, "rst_rel");

        // Basic match then a trailing 0.
        seq(5, 16'b10010, 16'b00010, 16'b00010, "basic");

        // 1001001: overlap flags at 4 and 7, non-overlap at 4 only;
        // then 1001 again flags on its 4th bit in both builds.
        do_reset("rst_t3");
        seq(7, 16'b1001001, 16'b0001001, 16'b0001000, "ovl7");
        seq(4, 16'b1001,    16'b0001,    16'b0001,    "again");

        // 10011001 flags twice in both builds.
        do_reset("rst_t4");
        seq(8, 16'b10011001, 16'b00010001, 16'b00010001, "dbl");

        // Near-misses never flag; 11001 flags once on bit 5.
        do_reset("rst_t5a");
        seq(11, 16'b10100011101, 16'b0, 16'b0, "miss");
        do_reset("rst_t5b");
        seq(5, 16'b11001, 16'b00001, 16'b00001, "ones");

        // Long runs of 0s and 1s never flag.
        seq(8, 16'b00000000, 16'b0, 16'b0, "zeros");
        seq(8, 16'b11111111, 16'b0, 16'b0, "onesrun");

        // Reset in the middle of 1,0,0 discards history; a following 1 is no match.
        do_reset("rst_t6");
        seq(3, 16'b100, 16'b000, 16'b000, "mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
        step(1'b1, 1'b1, 1'b0, 1'b0, "mid_after");

        // Random stream with glitches driven around the falling edge.
        do_reset("rst_rand");
        hist_o = '0; hist_n = '0; cnt_o = 0; cnt_n = 0;
        void'($urandom(15));
        for (int i = 0; i < 300; i++) begin
            g   = 1'($urandom_range(0, 1));
            din = g;                       // glitch after rising edge, ignored
            @(negedge clk);
            b   = 1'($urandom_range(0, 1));
            din = b;                       // the value sampled next rising edge
            #2;
            din = ~b;                      // brief glitch well before the edge
            #1;
            din = b;
            @(posedge clk);
            #1;
            din = 1'($urandom_range(0, 1)); // post-edge change, ignored

            hist_o = {hist_o[2:0], b};
            if (cnt_o < 4) cnt_o++;
            m_o = (cnt_o >= 4) && (hist_o == 4'b1001);

            hist_n = {hist_n[2:0], b};
            if (cnt_n < 4) cnt_n++;
            m_n = (cnt_n >= 4) && (hist_n == 4'b1001);
            if (m_n) cnt_n = 0;

            chk($sformatf("rand%0d_ovl", i), out_o, m_o);
            chk($sformatf("rand%0d_non", i), out_n, m_n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
